// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared state encoding and default timing for the button debouncer
package btn_debounce_pkg;

  // Per-channel FSM states; encoding is shared with the display and top-level blocks.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HELD = 3'd2,
    ST_RPT  = 3'd3,
    ST_REL  = 3'd4
  } state_t;

  // Default timing at 100 MHz: 10 ms debounce, 0.5 s long press, 0.1 s repeat.
  localparam int DEF_N            = 6;
  localparam int DEF_DEBOUNCE_CYC = 1000000;
  localparam int DEF_LONG_CYC     = 50000000;
  localparam int DEF_REPEAT_CYC   = 10000000;

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button levels in, clean levels and event pulses out
interface btn_debounce_if #(
  parameter int N = 6
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;
  logic [N-1:0] btn_repeat;

  // Master drives the raw buttons and consumes the events.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_long, btn_repeat
  );

  // Slave is the debouncer itself.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_long, btn_repeat
  );
endinterface

// File: rtl/btn_debounce_chan.sv
// rtl/btn_debounce_chan.sv - synchroniser, debounce FSM and hold/repeat counters for one button
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(LONG_CYC);
  localparam int RW = $clog2(REPEAT_CYC);

  // Terminal counts; every counter only ever needs to reach CYC-1.
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);

  logic          sync1, sync2;
  state_t        state, state_n;
  logic          ret_rpt, ret_rpt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          level_n, press_n, release_n, long_n, repeat_n;
  logic          s;

  assign s = sync2;

  // Two-flop synchroniser for the asynchronous raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // State, counters and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ret_rpt     <= 1'b0;
      dcnt        <= '0;
      hcnt        <= '0;
      rcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state       <= state_n;
      ret_rpt     <= ret_rpt_n;
      dcnt        <= dcnt_n;
      hcnt        <= hcnt_n;
      rcnt        <= rcnt_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      btn_long    <= long_n;
      btn_repeat  <= repeat_n;
    end
  end

  // Next-state logic; hold/repeat counters saturate so a release bounce never wraps them.
  always_comb begin
    state_n   = state;
    ret_rpt_n = ret_rpt;
    dcnt_n    = dcnt;
    hcnt_n    = hcnt;
    rcnt_n    = rcnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s) begin
          state_n = ST_ARM;
          dcnt_n  = DW'(1);
        end
      end
      ST_ARM: begin
        if (!s) begin
          state_n = ST_IDLE;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n = ST_HELD;
          press_n = 1'b1;
          level_n = 1'b1;
          dcnt_n  = '0;
          hcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      ST_HELD: begin
        if (hcnt != H_LAST) hcnt_n = hcnt + HW'(1);
        if (!s) begin
          state_n   = ST_REL;
          dcnt_n    = DW'(1);
          ret_rpt_n = 1'b0;
        end else if (hcnt == H_LAST) begin
          state_n = ST_RPT;
          long_n  = 1'b1;
          rcnt_n  = '0;
        end
      end
      ST_RPT: begin
        if (rcnt != R_LAST) rcnt_n = rcnt + RW'(1);
        if (!s) begin
          state_n   = ST_REL;
          dcnt_n    = DW'(1);
          ret_rpt_n = 1'b1;
        end else if (rcnt == R_LAST) begin
          repeat_n = 1'b1;
          rcnt_n   = '0;
        end
      end
      ST_REL: begin
        if (s) begin
          // Release bounce: resume where we were, counters untouched.
          state_n = ret_rpt ? ST_RPT : ST_HELD;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
          level_n   = 1'b0;
          dcnt_n    = '0;
          hcnt_n    = '0;
          rcnt_n    = '0;
          ret_rpt_n = 1'b0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        dcnt_n  = '0;
        hcnt_n  = '0;
        rcnt_n  = '0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - N-channel button debouncer wrapper with parameter legality checks
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input logic           clk,
  input logic           rst_n,
  btn_debounce_if.slave bus
);

  // Reject illegal timing at elaboration.
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYC must be >= 2");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("btn_debounce: LONG_CYC must be > DEBOUNCE_CYC");
  end
  if (REPEAT_CYC < 2) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_CYC must be >= 2");
  end

  logic [N-1:0] level, press, rel, lng, rpt;

  // One independent debouncer per button.
  for (genvar i = 0; i < N; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (bus.btn_raw[i]),
      .btn_level  (level[i]),
      .btn_press  (press[i]),
      .btn_release(rel[i]),
      .btn_long   (lng[i]),
      .btn_repeat (rpt[i])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.btn_long    = lng;
  assign bus.btn_repeat  = rpt;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized and directed self-checking bench for btn_debounce
module tb_btn_debounce;
  localparam int N = 6;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  btn_debounce_if #(.N(N)) bus ();

  btn_debounce #(
    .N(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: synchronised sample s is raw delayed two edges; the level flips once
  // D consecutive samples disagree with it; hold/repeat time accrues on edges whose
  // previous sample was high.
  logic [N-1:0] m_a, m_b, sp;
  logic [N-1:0] e_level, e_press, e_rel, e_long, e_rep;
  int           run[N], h[N], r[N];
  bit           lvl[N], ph[N];

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] s;
    if (!rst_n) begin
      m_a = '0; m_b = '0; sp = '0;
      e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      for (int c = 0; c < N; c++) begin
        run[c] = 0; h[c] = 0; r[c] = 0; lvl[c] = 0; ph[c] = 0;
      end
    end else begin
      s = m_b;
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      for (int c = 0; c < N; c++) begin
        if (!lvl[c]) begin
          run[c] = s[c] ? run[c] + 1 : 0;
          if (run[c] == D) begin
            lvl[c] = 1; e_press[c] = 1'b1; run[c] = 0; h[c] = 0; r[c] = 0; ph[c] = 0;
          end
        end else begin
          run[c] = !s[c] ? run[c] + 1 : 0;
          if (run[c] == D) begin
            lvl[c] = 0; e_rel[c] = 1'b1; run[c] = 0;
          end else if (sp[c]) begin
            if (!ph[c]) begin
              h[c]++;
              if (h[c] >= L && s[c]) begin e_long[c] = 1'b1; ph[c] = 1; r[c] = 0; end
            end else begin
              r[c]++;
              if (r[c] >= R && s[c]) begin e_rep[c] = 1'b1; r[c] = 0; end
            end
          end
        end
        e_level[c] = lvl[c];
      end
      sp  = s;
      m_b = m_a;
      m_a = bus.btn_raw;
    end
  end

  // Compare process plus event log used by the directed literal checks.
  int press_cnt[N], rel_cnt[N], press_cyc[N], rel_cyc[N], long_cyc[N];
  int rep1_q[$];
  int all_press_seen = 0, all_rel_seen = 0;

  always @(negedge clk) begin
    check("outputs",
          {34'd0, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_repeat},
          {34'd0, e_level, e_press, e_rel, e_long, e_rep});
    for (int c = 0; c < N; c++) begin
      if (bus.btn_press[c])   begin press_cnt[c]++; press_cyc[c] = cyc; end
      if (bus.btn_release[c]) begin rel_cnt[c]++;   rel_cyc[c] = cyc;   end
      if (bus.btn_long[c])    long_cyc[c] = cyc;
    end
    if (bus.btn_repeat[1]) rep1_q.push_back(cyc);
    if (bus.btn_press == {N{1'b1}})   all_press_seen++;
    if (bus.btn_release == {N{1'b1}}) all_rel_seen++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e, f, p0, r0, q0, a0;

  initial begin
    bus.btn_raw = '0;
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; press_cyc[c] = 0; rel_cyc[c] = 0; long_cyc[c] = 0;
    end
    wait_n(3);
    check("reset_outputs",
          {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_repeat}, 0);
    rst_n = 1'b1;
    wait_n(3);

    // Clean press on channel 0.
    p0 = press_cnt[0];
    e = cyc + 1;
    bus.btn_raw[0] = 1'b1;
    wait_n(10);
    check("clean_press_latency", press_cyc[0] - e, 5);
    check("clean_press_count", press_cnt[0] - p0, 1);
    check("clean_level", {bus.btn_level}, 6'b000001);
    f = cyc + 1;
    bus.btn_raw[0] = 1'b0;
    wait_n(10);
    check("clean_release_latency", rel_cyc[0] - f, 5);
    check("clean_level_low", bus.btn_level, 0);

    // Bouncy press and release on channel 2.
    p0 = press_cnt[2];
    r0 = rel_cnt[2];
    bus.btn_raw[2] = 1'b1; wait_n(1);
    bus.btn_raw[2] = 1'b0; wait_n(1);
    bus.btn_raw[2] = 1'b1; wait_n(2);
    bus.btn_raw[2] = 1'b0; wait_n(1);
    e = cyc + 1;
    bus.btn_raw[2] = 1'b1;
    wait_n(12);
    check("bouncy_press_count", press_cnt[2] - p0, 1);
    check("bouncy_press_latency", press_cyc[2] - e, 5);
    bus.btn_raw[2] = 1'b0; wait_n(1);
    bus.btn_raw[2] = 1'b1; wait_n(1);
    f = cyc + 1;
    bus.btn_raw[2] = 1'b0;
    wait_n(12);
    check("bouncy_release_count", rel_cnt[2] - r0, 1);
    check("bouncy_release_latency", rel_cyc[2] - f, 5);
    check("bouncy_no_repress", press_cnt[2] - p0, 1);

    // Long press and auto-repeat on channel 1.
    q0 = rep1_q.size();
    e = cyc + 1;
    bus.btn_raw[1] = 1'b1;
    wait_n(60);
    f = cyc + 1;
    bus.btn_raw[1] = 1'b0;
    wait_n(14);
    check("long_press_latency", press_cyc[1] - e, 5);
    check("long_offset", long_cyc[1] - press_cyc[1], 20);
    check("repeat_count", rep1_q.size() - q0, 4);
    if (rep1_q.size() >= q0 + 2) begin
      check("repeat1_offset", rep1_q[q0] - press_cyc[1], 28);
      check("repeat2_offset", rep1_q[q0+1] - press_cyc[1], 36);
    end else begin
      check("repeat_present", rep1_q.size() - q0, 2);
    end
    check("long_release_latency", rel_cyc[1] - f, 5);

    // Two-cycle release glitch while held on channel 3.
    p0 = press_cnt[3];
    r0 = rel_cnt[3];
    e = cyc + 1;
    bus.btn_raw[3] = 1'b1;
    wait_n(8);
    bus.btn_raw[3] = 1'b0;
    wait_n(2);
    bus.btn_raw[3] = 1'b1;
    wait_n(30);
    check("glitch_press_count", press_cnt[3] - p0, 1);
    check("glitch_no_release", rel_cnt[3] - r0, 0);
    check("glitch_long_offset", long_cyc[3] - press_cyc[3], 22);
    bus.btn_raw[3] = 1'b0;
    wait_n(12);

    // All channels together.
    a0 = all_press_seen;
    bus.btn_raw = {N{1'b1}};
    wait_n(10);
    check("all_press_coincide", all_press_seen - a0, 1);
    a0 = all_rel_seen;
    bus.btn_raw = '0;
    wait_n(10);
    check("all_release_coincide", all_rel_seen - a0, 1);

    // Asynchronous reset while channel 4 is repeating.
    bus.btn_raw[4] = 1'b1;
    wait_n(34);
    check("pre_reset_level", bus.btn_level[4], 1);
    #2 rst_n = 1'b0;
    #1 check("reset_async_outputs",
             {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_repeat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    f = cyc + 1;
    wait_n(10);
    check("post_reset_press_latency", press_cyc[4] - f, 5);
    bus.btn_raw[4] = 1'b0;
    wait_n(12);

    // Randomized traffic with occasional reset pulses; checked by the compare process.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 2 + 8 * c) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.btn_raw = '0;
    wait_n(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
